// File: rtl/bf_machine.sv
// Brainfuck interpreter: loads a program byte-stream, clears data memory,
// then executes with byte I/O through a simple rx/tx handshake.
module bf_machine #(
  parameter int PSIZELOG = 8,
  parameter int MSIZELOG = 8,
  parameter int CWIDTH   = 8,
  parameter int NESTLOG  = 5,
  parameter int MPWRAP   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       new_rx,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic [2:0] state,
  output logic [4:0] err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CLEAR = 3'd2,
    S_EXEC  = 3'd3,
    S_SKIPR = 3'd4,
    S_SKIPL = 3'd5
  } state_t;

  localparam logic [2:0] OP_INC   = 3'd0;
  localparam logic [2:0] OP_DEC   = 3'd1;
  localparam logic [2:0] OP_LEFT  = 3'd2;
  localparam logic [2:0] OP_RIGHT = 3'd3;
  localparam logic [2:0] OP_JZ    = 3'd4;
  localparam logic [2:0] OP_JNZ   = 3'd5;
  localparam logic [2:0] OP_OUT   = 3'd6;
  localparam logic [2:0] OP_IN    = 3'd7;

  localparam int E_POVER   = 4;
  localparam int E_MPUNDER = 3;
  localparam int E_MPOVER  = 2;
  localparam int E_NEST    = 1;
  localparam int E_UNM     = 0;

  localparam int PDEPTH_N = 1 << PSIZELOG;
  localparam int MDEPTH_N = 1 << MSIZELOG;
  localparam logic WRAP   = (MPWRAP != 0);

  localparam logic [PSIZELOG:0]   P_ZERO  = {(PSIZELOG+1){1'b0}};
  localparam logic [PSIZELOG:0]   P_ONE   = {{PSIZELOG{1'b0}}, 1'b1};
  localparam logic [PSIZELOG:0]   P_DEPTH = {1'b1, {PSIZELOG{1'b0}}};
  localparam logic [MSIZELOG-1:0] M_ZERO  = {MSIZELOG{1'b0}};
  localparam logic [MSIZELOG-1:0] M_ONE   = {{(MSIZELOG-1){1'b0}}, 1'b1};
  localparam logic [MSIZELOG-1:0] M_MAX   = {MSIZELOG{1'b1}};
  localparam logic [NESTLOG-1:0]  N_ZERO  = {NESTLOG{1'b0}};
  localparam logic [NESTLOG-1:0]  N_ONE   = {{(NESTLOG-1){1'b0}}, 1'b1};
  localparam logic [NESTLOG-1:0]  N_MAX   = {NESTLOG{1'b1}};
  localparam logic [CWIDTH-1:0]   C_ZERO  = {CWIDTH{1'b0}};
  localparam logic [CWIDTH-1:0]   C_ONE   = {{(CWIDTH-1){1'b0}}, 1'b1};

  function automatic logic f_is_cmd(input logic [7:0] b);
    case (b)
      8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h5B, 8'h5D, 8'h2E, 8'h2C: f_is_cmd = 1'b1;
      default: f_is_cmd = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] f_encode(input logic [7:0] b);
    case (b)
      8'h2B:   f_encode = OP_INC;
      8'h2D:   f_encode = OP_DEC;
      8'h3C:   f_encode = OP_LEFT;
      8'h3E:   f_encode = OP_RIGHT;
      8'h5B:   f_encode = OP_JZ;
      8'h5D:   f_encode = OP_JNZ;
      8'h2E:   f_encode = OP_OUT;
      8'h2C:   f_encode = OP_IN;
      default: f_encode = OP_INC;
    endcase
  endfunction

  logic [2:0]        r_prog [0:PDEPTH_N-1];
  logic [CWIDTH-1:0] r_mem  [0:MDEPTH_N-1];

  state_t              r_state;
  logic [PSIZELOG:0]   r_pc;
  logic [PSIZELOG:0]   r_plen;
  logic [MSIZELOG-1:0] r_mp;
  logic [NESTLOG-1:0]  r_nest;
  logic [4:0]          r_err;

  logic [2:0]          w_op;
  logic [CWIDTH-1:0]   w_cell;
  logic                w_at_end;
  logic                w_pc_zero;
  logic [PSIZELOG:0]   w_plen_eff;
  logic                w_rx_cmd;
  logic [2:0]          w_rx_op;
  logic                w_prog_we;
  logic                w_mem_we;
  logic [CWIDTH-1:0]   w_mem_wdata;

  assign w_op       = r_prog[r_pc[PSIZELOG-1:0]];
  assign w_cell     = r_mem[r_mp];
  assign w_at_end   = (r_pc == r_plen);
  assign w_pc_zero  = (r_pc == P_ZERO);
  // The byte that wakes Idle is a Load byte against a fresh, empty program.
  assign w_plen_eff = (r_state == S_IDLE) ? P_ZERO : r_plen;
  assign w_rx_cmd   = f_is_cmd(rx_data);
  assign w_rx_op    = f_encode(rx_data);
  assign w_prog_we  = ((r_state == S_IDLE) || (r_state == S_LOAD)) && new_rx &&
                      w_rx_cmd && (w_plen_eff != P_DEPTH);

  assign tx_data = w_cell[7:0];
  assign tx_send = (r_state == S_EXEC) && !w_at_end && (w_op == OP_OUT) && !tx_busy;
  assign state   = r_state;
  assign err     = r_err;

  // Data-memory write port: Clear zero-fill and cell-modifying instructions.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_wdata = C_ZERO;
    case (r_state)
      S_CLEAR: w_mem_we = 1'b1;
      S_EXEC: begin
        if (!w_at_end) begin
          case (w_op)
            OP_INC: begin
              w_mem_we    = 1'b1;
              w_mem_wdata = w_cell + C_ONE;
            end
            OP_DEC: begin
              w_mem_we    = 1'b1;
              w_mem_wdata = w_cell - C_ONE;
            end
            OP_IN: begin
              w_mem_we    = new_rx;
              w_mem_wdata = CWIDTH'(rx_data);
            end
            default: w_mem_we = 1'b0;
          endcase
        end else begin
          w_mem_we = 1'b0;
        end
      end
      default: w_mem_we = 1'b0;
    endcase
  end

  // Program and data stores (no reset).
  always_ff @(posedge clk) begin
    if (w_prog_we) begin
      r_prog[w_plen_eff[PSIZELOG-1:0]] <= w_rx_op;
    end
    if (w_mem_we) begin
      r_mem[r_mp] <= w_mem_wdata;
    end
  end

  // Main control FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= P_ZERO;
      r_plen  <= P_ZERO;
      r_mp    <= M_ZERO;
      r_nest  <= N_ZERO;
      r_err   <= 5'b00000;
    end else begin
      case (r_state)
        S_IDLE, S_LOAD: begin
          if (new_rx) begin
            if (r_state == S_IDLE) begin
              r_err <= 5'b00000;
            end
            if (rx_data == 8'h21) begin
              r_plen  <= w_plen_eff;
              r_mp    <= M_ZERO;
              r_state <= S_CLEAR;
            end else if (w_rx_cmd) begin
              if (w_plen_eff == P_DEPTH) begin
                r_err[E_POVER] <= 1'b1;
                r_state        <= S_IDLE;
              end else begin
                r_plen  <= w_plen_eff + P_ONE;
                r_state <= S_LOAD;
              end
            end else begin
              r_plen  <= w_plen_eff;
              r_state <= S_LOAD;
            end
          end
        end

        // r_mp doubles as the clear address and wraps back to 0 on exit.
        S_CLEAR: begin
          r_mp <= r_mp + M_ONE;
          if (r_mp == M_MAX) begin
            r_pc    <= P_ZERO;
            r_state <= S_EXEC;
          end
        end

        S_EXEC: begin
          if (w_at_end) begin
            r_state <= S_IDLE;
          end else begin
            case (w_op)
              OP_INC, OP_DEC: r_pc <= r_pc + P_ONE;
              OP_LEFT: begin
                if (!WRAP && (r_mp == M_ZERO)) begin
                  r_err[E_MPUNDER] <= 1'b1;
                  r_state          <= S_IDLE;
                end else begin
                  r_mp <= r_mp - M_ONE;
                  r_pc <= r_pc + P_ONE;
                end
              end
              OP_RIGHT: begin
                if (!WRAP && (r_mp == M_MAX)) begin
                  r_err[E_MPOVER] <= 1'b1;
                  r_state         <= S_IDLE;
                end else begin
                  r_mp <= r_mp + M_ONE;
                  r_pc <= r_pc + P_ONE;
                end
              end
              OP_JZ: begin
                r_nest <= N_ZERO;
                r_pc   <= r_pc + P_ONE;
                if (w_cell == C_ZERO) begin
                  r_state <= S_SKIPR;
                end
              end
              OP_JNZ: begin
                r_nest <= N_ZERO;
                if (w_cell == C_ZERO) begin
                  r_pc <= r_pc + P_ONE;
                end else if (w_pc_zero) begin
                  r_err[E_UNM] <= 1'b1;
                  r_state      <= S_IDLE;
                end else begin
                  r_pc    <= r_pc - P_ONE;
                  r_state <= S_SKIPL;
                end
              end
              OP_OUT: begin
                if (!tx_busy) begin
                  r_pc <= r_pc + P_ONE;
                end
              end
              OP_IN: begin
                if (new_rx) begin
                  r_pc <= r_pc + P_ONE;
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end

        S_SKIPR: begin
          if (w_at_end) begin
            r_err[E_UNM] <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            case (w_op)
              OP_JZ: begin
                if (r_nest == N_MAX) begin
                  r_err[E_NEST] <= 1'b1;
                  r_state       <= S_IDLE;
                end else begin
                  r_nest <= r_nest + N_ONE;
                  r_pc   <= r_pc + P_ONE;
                end
              end
              OP_JNZ: begin
                r_pc <= r_pc + P_ONE;
                if (r_nest != N_ZERO) begin
                  r_nest <= r_nest - N_ONE;
                end else begin
                  r_state <= S_EXEC;
                end
              end
              default: r_pc <= r_pc + P_ONE;
            endcase
          end
        end

        // Stepping left from pc 0 means no matching '[' exists.
        S_SKIPL: begin
          case (w_op)
            OP_JNZ: begin
              if (r_nest == N_MAX) begin
                r_err[E_NEST] <= 1'b1;
                r_state       <= S_IDLE;
              end else if (w_pc_zero) begin
                r_err[E_UNM] <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_nest <= r_nest + N_ONE;
                r_pc   <= r_pc - P_ONE;
              end
            end
            OP_JZ: begin
              if (r_nest == N_ZERO) begin
                r_pc    <= r_pc + P_ONE;
                r_state <= S_EXEC;
              end else if (w_pc_zero) begin
                r_err[E_UNM] <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_nest <= r_nest - N_ONE;
                r_pc   <= r_pc - P_ONE;
              end
            end
            default: begin
              if (w_pc_zero) begin
                r_err[E_UNM] <= 1'b1;
                r_state      <= S_IDLE;
              end else begin
                r_pc <= r_pc - P_ONE;
              end
            end
          endcase
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bf_machine.sv
// Directed bench for bf_machine: one instance with pointer errors, one with
// pointer wrap, both driven from the same stimulus.
module tb_bf_machine;

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       new_rx  = 1'b0;
  logic       tx_busy = 1'b0;

  logic [7:0] tx_data, tx_data_w;
  logic       tx_send, tx_send_w;
  logic [2:0] state, state_w;
  logic [4:0] err, err_w;

  int         n_pass    = 0;
  int         n_total   = 0;
  int         tx_count  = 0;
  int         clear_cnt = 0;
  logic [7:0] last_tx   = 8'h00;
  int         t0;
  int         c0;

  bf_machine #(.MPWRAP(0)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx(new_rx),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .state(state), .err(err)
  );

  bf_machine #(.MPWRAP(1)) dut_w (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx(new_rx),
    .tx_data(tx_data_w), .tx_send(tx_send_w), .tx_busy(tx_busy),
    .state(state_w), .err(err_w)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_send) begin
      tx_count = tx_count + 1;
      last_tx  = tx_data;
    end
    if (state == 3'd2) begin
      clear_cnt = clear_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #2;
    rx_data = b;
    new_rx  = 1'b1;
    @(posedge clk); #2;
    new_rx  = 1'b0;
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(s[i]);
    end
  endtask

  task automatic wait_state(input logic [2:0] st, input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (state == st) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_state", state, 3'd0);
    check("rst_err", err, 5'b00000);
    check("rst_tx_send", tx_send, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;

    // "+++.!" -> one byte 0x03 after a full clear
    t0 = tx_count; c0 = clear_cnt;
    load("+++.!");
    wait_state(3'd0, "t34_done");
    check("t34_clear_cycles", clear_cnt - c0, 256);
    check("t34_tx_count", tx_count - t0, 1);
    check("t34_tx_data", last_tx, 8'h03);
    check("t34_err", err, 5'b00000);

    // ",+.!" with input 0x41 and a stalled transmitter
    @(posedge clk); #2;
    tx_busy = 1'b1;
    t0 = tx_count;
    load(",+.!");
    wait_state(3'd3, "t35_exec");
    send_byte(8'h41);
    repeat (5) @(negedge clk);
    check("t35_stall_tx", tx_count - t0, 0);
    check("t35_stall_pc", dut.r_pc, 2);
    check("t35_stall_state", state, 3'd3);
    @(posedge clk); #2;
    tx_busy = 1'b0;
    wait_state(3'd0, "t35_done");
    check("t35_tx_count", tx_count - t0, 1);
    check("t35_tx_data", last_tx, 8'h42);
    check("t35_err", err, 5'b00000);

    // "<!" -> underflow error, or silent wrap
    load("<!");
    wait_state(3'd0, "t36_done");
    repeat (4) @(negedge clk);
    check("t36_err", err, 5'b01000);
    check("t36_state", state, 3'd0);
    check("t36w_err", err_w, 5'b00000);
    check("t36w_state", state_w, 3'd0);
    check("t36w_mp", dut_w.r_mp, 8'hFF);
    check("t36w_cell", tx_data_w, 8'h00);

    // nested skip over a zero cell
    t0 = tx_count;
    load("[[+]]+.!");
    wait_state(3'd0, "t37_done");
    check("t37_tx_count", tx_count - t0, 1);
    check("t37_tx_data", last_tx, 8'h01);
    check("t37_err", err, 5'b00000);

    load("[!");
    wait_state(3'd0, "t37u_done");
    check("t37u_err", err, 5'b00001);

    // backward loop with a discarded non-command byte
    t0 = tx_count;
    load("++[>+<-]x>.!");
    wait_state(3'd0, "tloop_done");
    check("tloop_tx_count", tx_count - t0, 1);
    check("tloop_tx_data", last_tx, 8'h02);
    check("tloop_err", err, 5'b00000);

    // 33 nested '[' overflow the 5-bit skip counter
    for (int i = 0; i < 33; i++) begin
      send_byte(8'h5B);
    end
    send_byte(8'h21);
    wait_state(3'd0, "tnest_done");
    check("tnest_err", err, 5'b00010);

    // 0 - 1 wraps to 0xFF
    t0 = tx_count;
    load("-.!");
    wait_state(3'd0, "t38_done");
    check("t38_tx_data", last_tx, 8'hFF);
    check("t38_tx_count", tx_count - t0, 1);

    // 257 commands overflow a 256-entry program store
    for (int i = 0; i < 257; i++) begin
      send_byte(8'h2B);
    end
    @(negedge clk);
    check("t38p_err", err, 5'b10000);
    check("t38p_state", state, 3'd0);

    // reset mid-Clear, then a fresh load
    load("+.!");
    repeat (10) @(negedge clk);
    check("t39_in_clear", state, 3'd2);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t39_async_state", state, 3'd0);
    check("t39_async_err", err, 5'b00000);
    @(posedge clk); #2;
    rst = 1'b0;
    t0 = tx_count;
    load("++.!");
    wait_state(3'd0, "t39_done");
    check("t39_tx_count", tx_count - t0, 1);
    check("t39_tx_data", last_tx, 8'h02);
    check("t39_err", err, 5'b00000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
